// File: rtl/smem_arbiter.sv
// Round-robin shared-memory arbiter: NUM_CORES level-held load/store ports onto one 8-bit scratch RAM.
// Optional SMEM_ACCESS_CNT_EN adds ld_count/st_count access counters and a sticky host_viol flag.

module smem_lockout #(
  parameter int LW      = 1,
  parameter int LOCKOUT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic clear
);
  logic [LW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)           cnt <= '0;
    else if (load)       cnt <= LW'(LOCKOUT);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign clear = (cnt == '0);
endmodule

module smem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int LOCKOUT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req_ld,
  input  logic [NUM_CORES-1:0]        mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_in,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0]           mem_dat,
  output logic [NUM_CORES-1:0]        val_data,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
`ifdef SMEM_ACCESS_CNT_EN
  output logic [15:0]                 ld_count,
  output logic [15:0]                 st_count,
  output logic                        host_viol,
`endif
  output logic                        busy
);
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]    mem [2**ADDR_W];
  logic [NUM_CORES-1:0] elig, lk_clear;
  logic [IW-1:0]        rr_ptr, gnt_q, pick;
  logic                 found, op_ld;
  logic [ADDR_W-1:0]    addr_q, addr_sel;
  logic [DATA_W-1:0]    wdata_q, wdata_sel;
  logic [IW:0]          sum;
  logic                 grant;

  genvar k;
  generate
    for (k = 0; k < NUM_CORES; k++) begin : g_lane
      smem_lockout #(.LW(LW), .LOCKOUT(LOCKOUT)) u_lk (
        .clk   (clk),
        .reset (reset),
        .load  (state == RESP && gnt_q == IW'(k)),
        .clear (lk_clear[k])
      );
      assign elig[k] = (mem_req_ld[k] | mem_req_st[k]) & lk_clear[k];
    end
  endgenerate

  // First eligible core at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_CORES)) sum = sum - (IW+1)'(NUM_CORES);
      if (!found && elig[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick == IW'(i)) begin
        addr_sel  = addr_in[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Host preload owns the RAM in IDLE, so it blocks any grant that cycle.
  assign grant = (state == IDLE) && !host_we && found;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    val_data = '0;
    if (state == RESP) val_data[gnt_q] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      op_ld   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rr_ptr  <= '0;
      mem_dat <= '0;
    end else begin
      if (grant) begin
        gnt_q   <= pick;
        op_ld   <= mem_req_ld[pick];
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
      end
      if (state == ACCESS && op_ld) mem_dat <= mem[addr_q];
      if (state == RESP)
        rr_ptr <= (gnt_q == IW'(NUM_CORES-1)) ? '0 : gnt_q + 1'b1;
    end
  end

  // RAM is never cleared; reset only suppresses writes in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && host_we)       mem[host_addr] <= host_wdata;
      else if (state == ACCESS && !op_ld) mem[addr_q]    <= wdata_q;
    end
  end

`ifdef SMEM_ACCESS_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_count  <= '0;
      st_count  <= '0;
      host_viol <= 1'b0;
    end else begin
      if (state == RESP && op_ld && ld_count != 16'hFFFF)  ld_count <= ld_count + 1'b1;
      if (state == RESP && !op_ld && st_count != 16'hFFFF) st_count <= st_count + 1'b1;
      if (host_we && busy) host_viol <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_smem_arbiter.sv
// Scoreboard bench for smem_arbiter: directed requests push expected responses, a monitor pops on val_data.

module tb_smem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_req_ld, mem_req_st;
  logic [47:0] addr_in;
  logic [31:0] wdata_in;
  logic [7:0]  mem_dat;
  logic [3:0]  val_data;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        busy;
`ifdef SMEM_ACCESS_CNT_EN
  logic [15:0] ld_count, st_count;
  logic        host_viol;
`endif

  smem_arbiter #(.NUM_CORES(4), .ADDR_W(12), .DATA_W(8), .LOCKOUT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req_ld (mem_req_ld),
    .mem_req_st (mem_req_st),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .mem_dat    (mem_dat),
    .val_data   (val_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
`ifdef SMEM_ACCESS_CNT_EN
    .ld_count   (ld_count),
    .st_count   (st_count),
    .host_viol  (host_viol),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] vd;
    logic [7:0] dat;
    int         cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && val_data != 4'b0) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got val_data %b expected none (cycle %0d)", val_data, cyc);
      end else begin
        e = q.pop_front();
        chk("val_data", 32'(val_data), 32'(e.vd));
        chk("mem_dat", 32'(mem_dat), 32'(e.dat));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input logic [3:0] vd, input logic [7:0] dat, input int c);
    exp_t x;
    x.vd = vd; x.dat = dat; x.cyc = c;
    q.push_back(x);
  endtask

  task automatic host_wr(input logic [11:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic req(input int k, input bit ld, input bit st, input logic [11:0] a, input logic [7:0] d);
    mem_req_ld[k] = ld;
    mem_req_st[k] = st;
    addr_in[k*12 +: 12] = a;
    wdata_in[k*8 +: 8]  = d;
  endtask

  // per=1 drops each core as it is served; per=0 keeps requests held until the n-th response.
  task automatic wait_resp(input int n, input bit per);
    int got = 0;
    int b   = 0;
    while (got < n && b < 40) begin
      @(negedge clk);
      b++;
      if (val_data != 4'b0) begin
        got++;
        if (per || got == n) begin
          mem_req_ld = mem_req_ld & ~val_data;
          mem_req_st = mem_req_st & ~val_data;
        end
      end
    end
    if (got < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", got, n);
      mem_req_ld = '0;
      mem_req_st = '0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ld = '0;
    mem_req_st = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int c;

  initial begin
    reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_req_ld = '0; mem_req_st = '0; addr_in = '0; wdata_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_val_data", 32'(val_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_dat", 32'(mem_dat), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Host preload then single load, latency 2.
    host_wr(12'h123, 8'hA5);
    c = cyc; req(2, 1, 0, 12'h123, 8'h00); push(4'b0100, 8'hA5, c + 2);
    wait_resp(1, 1);

    // Three simultaneous loads from rr_ptr=0.
    do_reset();
    host_wr(12'h001, 8'h11);
    host_wr(12'h002, 8'h22);
    host_wr(12'h003, 8'h33);
    c = cyc;
    req(0, 1, 0, 12'h001, 8'h00); req(1, 1, 0, 12'h002, 8'h00); req(3, 1, 0, 12'h003, 8'h00);
    push(4'b0001, 8'h11, c + 2); push(4'b0010, 8'h22, c + 5); push(4'b1000, 8'h33, c + 8);
    wait_resp(3, 1);

    // rr_ptr wrapped back to 0: core 0 wins over core 3.
    c = cyc;
    req(0, 1, 0, 12'h001, 8'h00); req(3, 1, 0, 12'h003, 8'h00);
    push(4'b0001, 8'h11, c + 2); push(4'b1000, 8'h33, c + 5);
    wait_resp(2, 1);

    // Held store re-served after lockout; mem_dat keeps last load.
    c = cyc;
    req(1, 0, 1, 12'h7FF, 8'h3C);
    push(4'b0010, 8'h33, c + 2); push(4'b0010, 8'h33, c + 6);
    wait_resp(2, 0);
    c = cyc; req(0, 1, 0, 12'h7FF, 8'h00); push(4'b0001, 8'h3C, c + 2);
    wait_resp(1, 1);

    // ld+st together behaves as a load and leaves RAM untouched.
    host_wr(12'h010, 8'h55);
    c = cyc; req(0, 1, 1, 12'h010, 8'hEE); push(4'b0001, 8'h55, c + 2);
    wait_resp(1, 1);
    c = cyc; req(3, 1, 0, 12'h010, 8'h00); push(4'b1000, 8'h55, c + 2);
    wait_resp(1, 1);

    // Reset during ACCESS of a store.
    req(2, 0, 1, 12'h020, 8'h9A);
    @(negedge clk);
    chk("access_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    mem_req_st = '0;
    @(negedge clk);
    chk("midrst_val_data", 32'(val_data), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_mem_dat", 32'(mem_dat), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);

`ifdef SMEM_ACCESS_CNT_EN
    do_reset();
    chk("rst_ld_count", 32'(ld_count), 32'h0);
    chk("rst_host_viol", 32'(host_viol), 32'h0);
    c = cyc; req(0, 1, 0, 12'h001, 8'h00); push(4'b0001, 8'h11, c + 2); wait_resp(1, 1);
    c = cyc; req(1, 1, 0, 12'h002, 8'h00); push(4'b0010, 8'h22, c + 2); wait_resp(1, 1);
    c = cyc; req(2, 1, 0, 12'h003, 8'h00); push(4'b0100, 8'h33, c + 2); wait_resp(1, 1);
    c = cyc; req(3, 0, 1, 12'h100, 8'h77); push(4'b1000, 8'h33, c + 2); wait_resp(1, 1);
    c = cyc; req(3, 0, 1, 12'h101, 8'h78); push(4'b1000, 8'h33, c + 2); wait_resp(1, 1);
    chk("ld_count", 32'(ld_count), 32'd3);
    chk("st_count", 32'(st_count), 32'd2);
    chk("host_viol_clear", 32'(host_viol), 32'h0);
    c = cyc; req(0, 1, 0, 12'h100, 8'h00); push(4'b0001, 8'h77, c + 2);
    @(negedge clk);
    host_we = 1'b1; host_addr = 12'h100; host_wdata = 8'h99;
    @(negedge clk);
    host_we = 1'b0;
    mem_req_ld = '0;
    repeat (2) @(negedge clk);
    chk("host_viol", 32'(host_viol), 32'h1);
    c = cyc; req(1, 1, 0, 12'h100, 8'h00); push(4'b0010, 8'h77, c + 2); wait_resp(1, 1);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
